// File: rtl/serial_uart_endpoint.sv
// serial_uart_endpoint
// CPU byte-wide serial port bridged to an asynchronous UART line.
// CPU writes pass through a TX FIFO to the serialiser. Received frames land in
// a show-ahead RX FIFO.
// Frame format: start(0), 8 data bits LSB first, optional parity bit, stop(1).
// Build option: define SERIAL_PARITY_EN to insert and check an even-parity bit.
module serial_uart_endpoint #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cpu_wdata,
   input  logic       cpu_wren,
   input  logic       cpu_rden,
   output logic [7:0] cpu_rdata,
   output logic       cpu_valid,
   output logic       cpu_ready,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic       frame_error,
   output logic       rx_overrun
);
   localparam int addrW = $clog2(FIFO_DEPTH);
   localparam int cntW  = $clog2(CLKS_PER_BIT);
   localparam logic [cntW-1:0] bitLast  = cntW'(CLKS_PER_BIT - 1);
   localparam logic [cntW-1:0] halfLast = cntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [cntW-1:0] cntOne   = cntW'(1);
   localparam logic [addrW:0]  ptrOne   = (addrW + 1)'(1);

`ifdef SERIAL_PARITY_EN
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} TxStateType;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxResync} RxStateType;
`else
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxStop} TxStateType;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxResync} RxStateType;
`endif

   // ---------------- TX FIFO ----------------
   logic [7:0]     txMem [FIFO_DEPTH];
   logic [addrW:0] txWr, txRd;
   logic           txEmpty, txFull, txPush, txPop;

   assign txEmpty   = (txWr == txRd);
   assign txFull    = (txWr[addrW] != txRd[addrW]) && (txWr[addrW-1:0] == txRd[addrW-1:0]);
   assign txPush    = cpu_wren && !txFull;
   assign cpu_ready = !txFull;

   // TX storage write
   always_ff @(posedge clock) begin
      if (txPush) txMem[txWr[addrW-1:0]] <= cpu_wdata;
   end

   // TX pointers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         txWr <= '0;
         txRd <= '0;
      end else begin
         if (txPush) txWr <= txWr + ptrOne;
         if (txPop)  txRd <= txRd + ptrOne;
      end
   end

   // ---------------- TX FSM ----------------
   TxStateType      txState, txStateNext;
   logic [cntW-1:0] txCnt;
   logic [2:0]      txBit, txBitNext;
   logic [7:0]      txByte;
   logic            txBitDone, txdNext;

   assign txBitDone = (txCnt == bitLast);

   // TX state register, bit timer, byte latch and registered line output
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         txState  <= TxIdle;
         txCnt    <= '0;
         txBit    <= '0;
         txByte   <= '0;
         uart_txd <= 1'b1;
      end else begin
         txState  <= txStateNext;
         txBit    <= txBitNext;
         uart_txd <= txdNext;
         if (txPop) txByte <= txMem[txRd[addrW-1:0]];
         if (txState == TxIdle || txBitDone) txCnt <= '0;
         else                                txCnt <= txCnt + cntOne;
      end
   end

   // TX next state and bit index
   always_comb begin
      txStateNext = txState;
      txBitNext   = txBit;
      case (txState)
         TxIdle:   if (!txEmpty) txStateNext = TxStart;
         TxStart:  if (txBitDone) txStateNext = TxData;
         TxData:   if (txBitDone) begin
                      txBitNext = txBit + 3'd1;
`ifdef SERIAL_PARITY_EN
                      if (txBit == 3'd7) txStateNext = TxParity;
`else
                      if (txBit == 3'd7) txStateNext = TxStop;
`endif
                   end
`ifdef SERIAL_PARITY_EN
         TxParity: if (txBitDone) txStateNext = TxStop;
`endif
         TxStop:   if (txBitDone) txStateNext = txEmpty ? TxIdle : TxStart;
         default:  txStateNext = TxIdle;
      endcase
   end

   // TX outputs: FIFO pop and the value the line register takes next
   always_comb begin
      txPop   = !txEmpty && ((txState == TxIdle) || (txState == TxStop && txBitDone));
      txdNext = 1'b1;
      case (txStateNext)
         TxStart:  txdNext = 1'b0;
         TxData:   txdNext = txByte[txBitNext];
`ifdef SERIAL_PARITY_EN
         TxParity: txdNext = ^txByte;
`endif
         default:  txdNext = 1'b1;
      endcase
   end

   // ---------------- RX synchroniser ----------------
   logic rxMeta, rxSync;

   // two-flop synchroniser, idles high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= uart_rxd;
         rxSync <= rxMeta;
      end
   end

   // ---------------- RX FSM ----------------
   RxStateType      rxState, rxStateNext;
   logic [cntW-1:0] rxCnt;
   logic [2:0]      rxBit, rxBitNext;
   logic [7:0]      rxShift;
   logic            rxTick, rxBad, rxPush, rxFrameErr;

   // START times a half bit to land later samples at mid-bit
   assign rxTick = (rxState == RxStart) ? (rxCnt == halfLast) : (rxCnt == bitLast);

`ifdef SERIAL_PARITY_EN
   logic rxParityBad;
   assign rxBad = !rxSync || rxParityBad;
`else
   assign rxBad = !rxSync;
`endif

   // RX state register, sample timer, shift register and frame-error flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rxState     <= RxIdle;
         rxCnt       <= '0;
         rxBit       <= '0;
         rxShift     <= '0;
         frame_error <= 1'b0;
`ifdef SERIAL_PARITY_EN
         rxParityBad <= 1'b0;
`endif
      end else begin
         rxState <= rxStateNext;
         rxBit   <= rxBitNext;
         if (rxState == RxIdle || rxState == RxResync || rxTick) rxCnt <= '0;
         else                                                 rxCnt <= rxCnt + cntOne;
         if (rxState == RxData && rxTick) rxShift <= {rxSync, rxShift[7:1]};
`ifdef SERIAL_PARITY_EN
         if (rxState == RxParity && rxTick) rxParityBad <= (rxSync != ^rxShift);
`endif
         if (rxFrameErr) frame_error <= 1'b1;
      end
   end

   // RX next state and bit index
   always_comb begin
      rxStateNext = rxState;
      rxBitNext   = rxBit;
      case (rxState)
         RxIdle:   if (!rxSync) rxStateNext = RxStart;
         RxStart:  if (rxTick) rxStateNext = rxSync ? RxIdle : RxData;
         RxData:   if (rxTick) begin
                      rxBitNext = rxBit + 3'd1;
`ifdef SERIAL_PARITY_EN
                      if (rxBit == 3'd7) rxStateNext = RxParity;
`else
                      if (rxBit == 3'd7) rxStateNext = RxStop;
`endif
                   end
`ifdef SERIAL_PARITY_EN
         RxParity: if (rxTick) rxStateNext = RxStop;
`endif
         RxStop:   if (rxTick) rxStateNext = rxBad ? RxResync : RxIdle;
         RxResync: if (rxSync) rxStateNext = RxIdle;
         default:  rxStateNext = RxIdle;
      endcase
   end

   // RX outputs: good-frame push or frame error at the stop sample
   always_comb begin
      rxPush     = (rxState == RxStop) && rxTick && !rxBad;
      rxFrameErr = (rxState == RxStop) && rxTick && rxBad;
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]     rxMem [FIFO_DEPTH];
   logic [addrW:0] rxWr, rxRd;
   logic           rxEmpty, rxFull, rxPop, rxWrite;

   assign rxEmpty   = (rxWr == rxRd);
   assign rxFull    = (rxWr[addrW] != rxRd[addrW]) && (rxWr[addrW-1:0] == rxRd[addrW-1:0]);
   assign rxPop     = cpu_rden && !rxEmpty;
   // a same-cycle pop frees the head slot, which is the one a full FIFO writes
   assign rxWrite   = rxPush && (!rxFull || rxPop);
   assign cpu_valid = !rxEmpty;
   assign cpu_rdata = rxEmpty ? '0 : rxMem[rxRd[addrW-1:0]];

   // RX storage write
   always_ff @(posedge clock) begin
      if (rxWrite) rxMem[rxWr[addrW-1:0]] <= rxShift;
   end

   // RX pointers and sticky overrun flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rxWr       <= '0;
         rxRd       <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (rxWrite) rxWr <= rxWr + ptrOne;
         if (rxPop)   rxRd <= rxRd + ptrOne;
         if (rxPush && rxFull && !rxPop) rx_overrun <= 1'b1;
      end
   end

endmodule
